// File: rtl/present80_core.sv
// present80_core: iterative PRESENT-80 encryptor, one round per clock, 32-cycle latency.
module present80_core (
  input  logic        clk,
  input  logic        iReset,
  input  logic        load,
  input  logic [63:0] idat,
  input  logic [79:0] key,
  output logic [63:0] odat,
  output logic        done,
  output logic        busy
);
  typedef enum logic {IDLE, RUN} st_t;
  localparam logic [63:0] SBOX = 64'h2174_8FE3_DA09_B65C;
  st_t st, st_nx;
  logic [63:0] s, x, sub, per;
  logic [79:0] k, krot, k_nx;
  logic [5:0] rc;
  function automatic logic [3:0] sb(input logic [3:0] v);
    sb = SBOX[{v, 2'b00} +: 4];
  endfunction
  assign x = s ^ k[79:16];
  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sub[4*i +: 4] = sb(x[4*i +: 4]);
  end
  for (genvar i = 0; i < 64; i++) begin : g_per
    assign per[i == 63 ? 63 : (16 * i) % 63] = sub[i];
  end
  assign krot = {k[18:0], k[79:19]};
  assign k_nx = {sb(krot[79:76]), krot[75:20], krot[19:15] ^ rc[4:0], krot[14:0]};
  assign busy = st == RUN;
  always_comb begin
    st_nx = st;
    if (st == IDLE) st_nx = load ? RUN : IDLE;
    else st_nx = rc == 6'd32 ? IDLE : RUN;
  end
  always_ff @(posedge clk or posedge iReset)
    if (iReset) st <= IDLE;
    else st <= st_nx;
  always_ff @(posedge clk or posedge iReset)
    if (iReset) begin
      s    <= '0;
      k    <= '0;
      rc   <= '0;
      odat <= '0;
      done <= 1'b0;
    end else if (st == IDLE) begin
      if (load) begin
        s    <= idat;
        k    <= key;
        rc   <= 6'd1;
        done <= 1'b0;
      end
    end else if (rc == 6'd32) begin
      odat <= x;
      done <= 1'b1;
    end else begin
      s  <= per;
      k  <= k_nx;
      rc <= rc + 6'd1;
    end
endmodule

// File: doc/present80_core.md
PRESENT80_CORE -- requirements
Module: present80_core

Interface
REQ-001 Parameters: none; fixed PRESENT-80 (64-bit block, 80-bit key, 31 rounds), encrypt-only.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 iReset  input  1  reset, asynchronous, active-high.
REQ-004 load  input  1  start request, sampled on rising clk; level or pulse accepted.
REQ-005 idat  input  64  plaintext block, sampled on the accepted load edge.
REQ-006 key  input  80  cipher key, sampled on the accepted load edge.
REQ-007 odat  output  64  ciphertext register, valid while done=1.
REQ-008 done  output  1  result valid, held high until next accepted load or reset.
REQ-009 busy  output  1  high while rounds are in progress.

Function
REQ-010 FSM states IDLE, RUN; state register reset to IDLE.
REQ-011 IDLE, load=1 at edge T: capture idat into state register, key into key register, round counter rc=1, clear done, go to RUN; busy=1 from T.
REQ-012 IDLE, load=0: hold all registers; done and odat unchanged.
REQ-013 RUN, each edge with rc=1..31: state <= P(S(state ^ K[79:16])); key <= keyupdate(K, rc); rc <= rc+1.
REQ-014 keyupdate: rotate K left by 61; apply S-box to bits [79:76]; XOR 5-bit rc into bits [19:15].
REQ-015 S-box, x=0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2, applied to all 16 nibbles in parallel.
REQ-016 P-layer: state bit i moves to bit (16*i) mod 63 for i=0..62; bit 63 stays at 63.
REQ-017 Edge with rc=32 (T+32): odat <= state ^ K[79:16] (K32), done <= 1, busy <= 0, go to IDLE.
REQ-018 Latency: load accepted at edge T -> done=1 and odat valid after edge T+32; exactly 31 round updates plus one whitening cycle.
REQ-019 load while busy=1: ignored; running operation, idat/key registers unaffected.
REQ-020 load held high continuously: new operation accepted on the first IDLE edge after done rises (back-to-back, done high for exactly one cycle).
REQ-021 load accepted while done=1: done cleared on that edge, odat retains the old value until overwritten at completion.
REQ-022 idat/key changes after the accepted load edge have no effect on the result.
REQ-023 rc is 6 bits wide; only values 1..32 are reachable; the 5 LSBs are used in REQ-014.

Reset
REQ-024 iReset=1 asynchronously forces: FSM=IDLE, odat=64'h0, done=0, busy=0, rc=0, state and key registers=0.
REQ-025 Reset asserted mid-RUN aborts the operation; no done pulse after release; the next load starts a fresh operation.
REQ-026 First load accepted on the first rising clk edge at which iReset=0.

Verification
REQ-027 idat=0, key=0, load pulse -> after 32 cycles done=1, odat=64'h5579C1387B228445, busy=0.
REQ-028 idat=0, key=80'hFFFF_FFFFFFFF_FFFFFFFF -> odat=64'hE72C46C0F5945049; idat=64'hFFFFFFFFFFFFFFFF, key=0 -> odat=64'hA112FFC72F68417B.
REQ-029 idat=all-ones, key=all-ones; toggle idat/key and pulse load at cycle 10 of RUN -> odat=64'h3333DCD3213210D2, done at cycle 32 only.
REQ-030 Assert iReset at cycle 15 of RUN for 2 cycles -> outputs 0 immediately (asynchronously, before next edge), no done; new load with zero vectors -> 64'h5579C1387B228445 after 32 cycles.
REQ-031 load held high across two operations with vectors of REQ-027 then REQ-028 -> done high for one cycle, odat second result 33 cycles after the first done.
